instr_encode_loader: RTL and testbench
======================================

// Module: instr_encode_loader
// PURPOSE
//  Inverse of the BUBBLE instruction decoder: accepts decoded fields (opcode ID, rs, rt, rd, imm) over a
//  valid/ready stream, packs them into 32-bit BUBBLE words, buffers them in a small FIFO and writes them
//  to consecutive instruction-memory addresses. Sits between the bench or host program loader and imem.
// PARAMETERS
//  ADDR_W     10  instruction-memory word-address width
//  FIFO_DEPTH 4   encoded-word buffer depth (power of 2, >=2)
// PORTS
//  clk        in  1       clock; all state on rising edge
//  reset      in  1       asynchronous, active-high; clears all state
//  start      in  1       pulse: begin load session (honoured in IDLE/DONE only)
//  base_addr  in  ADDR_W  first write address, sampled on accepted start
//  in_valid   in  1       field bundle valid
//  in_ready   out 1       = (state==LOAD) && !fifo_full && !last_seen
//  in_id      in  6       opcode ID
//  in_rs      in  5       rs field
//  in_rt      in  5       rt field
//  in_rd      in  5       rd field
//  in_imm     in  26      imm16 in [15:0] (I-type) / target in [25:0] (J-type)
//  in_last    in  1       marks final instruction of session
//  mem_busy   in  1       imem stalls writes while high
//  mem_we     out 1       write strobe, one word per cycle
//  mem_addr   out ADDR_W  write address
//  mem_wdata  out 32      encoded word
//  count      out ADDR_W  words written this session
//  done       out 1       high in DONE
//  err        out 1       sticky illegal-opcode flag
// BEHAVIOUR
//  - Reset: state IDLE, FIFO empty, mem_we=0, mem_addr=0, mem_wdata=0, count=0, done=0, err=0.
//  - FSM: IDLE -start-> LOAD (addr<=base_addr, count<=0, err<=0); LOAD -last accepted and FIFO drained-> DONE;
//    DONE -start-> LOAD. start while in LOAD is ignored.
//  - Formats: R (ADD,AND,SLT) = {id,rs,rt,rd,5'b0,6'b0}; I (ADDI,ORI,LW,SW) = {id,rs,rt,imm[15:0]};
//    J (J) = {id,imm[25:0]}. Unused input fields are ignored.
//  - Handshake: transfer when in_valid&&in_ready. The word is encoded combinationally and pushed in the same cycle.
//  - Drain: when FIFO is non-empty and !mem_busy, the next cycle has mem_we=1 with the head word at mem_addr.
//    Then addr++ and count++. Min latency accept->mem_we = 1 cycle. Throughput 1 word/cycle.
//  - Push and pop in the same cycle are both allowed when full: the pop frees the slot for the push.
//  - mem_addr wraps modulo 2^ADDR_W with no flag. count saturates at 2^ADDR_W-1.
//  - in_last accepted: in_ready drops. Move to DONE on the cycle after the final mem_we.
//  - mem_busy held high: FIFO fills, then in_ready=0. No word is lost or duplicated.
//  - Reset mid-session: FIFO contents are discarded, return to IDLE, no further mem_we.
// CONFIGURATION
//  ENC_ILLEGAL_TRAP_EN defined: an opcode outside the legal set sets err; the word is not pushed, in_ready
//    drops and the FSM enters DONE once the FIFO drains (session aborted).
//  Not defined: an illegal opcode sets err, the word is dropped, and the session continues normally.
// STRUCTURE
//  bubble_isa_pkg: opcode constants ADD=0 ADDI=1 AND=3 ORI=6 LW=8 SW=9 J=16 SLT=19;
//    format enum {FMT_R,FMT_I,FMT_J,FMT_ILL}; field bit positions; opcode->format function.
//  Sub-module enc_fifo: synchronous FIFO (FIFO_DEPTH x 32) with full/empty flags.
//  Top level contains the FSM, packer and address/count logic.
// TESTING
//  1 start base=0x010; add rs=3 rt=5 rd=1 -> mem_we @0x010, wdata 0x00650800
//  2 stream addi(2,1,100), lw(2,1,100), sw(2,1,100), last -> 0x04410064,0x20410064,0x24410064
//    @0x010..0x012; count=3; done=1
//  3 j imm=100 then slt rs=3 rt=6 rd=1 -> 0x40000064, 0x4C660800 back-to-back, one per cycle
//  4 mem_busy=1 for 10 cycles while streaming 6 words -> in_ready low after 4 accepts; all 6 words
//    written in order once busy drops
//  5 base=0x3FF, 2 words -> written to 0x3FF then 0x000
//  6 in_id=2 mid-stream -> err=1; TRAP_EN: session aborts to DONE; else skipped, next word at next addr;
//    reset mid-drain -> mem_we=0 from reset onward, state IDLE

Source files
------------

// File: rtl/bubble_isa_pkg.sv
// bubble_isa_pkg -- BUBBLE ISA constants shared by the instruction encoder.
// Opcode IDs, instruction format classes, field bit positions and the
// opcode -> format lookup used to choose the packing layout.
package bubble_isa_pkg;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_ORI  = 6'd6;
    localparam logic [5:0] OP_LW   = 6'd8;
    localparam logic [5:0] OP_SW   = 6'd9;
    localparam logic [5:0] OP_J    = 6'd16;
    localparam logic [5:0] OP_SLT  = 6'd19;

    typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J, FMT_ILL} fmt_t;

    // Field positions within a 32-bit BUBBLE word
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned IMM16_W = 16;
    localparam int unsigned TGT_W   = 26;

    function automatic fmt_t opcode_fmt(input logic [5:0] id);
        fmt_t f;
        case (id)
            OP_ADD, OP_AND, OP_SLT:        f = FMT_R;
            OP_ADDI, OP_ORI, OP_LW, OP_SW: f = FMT_I;
            OP_J:                          f = FMT_J;
            default:                       f = FMT_ILL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// enc_fifo -- synchronous FIFO holding encoded instruction words.
// Ports: clk, reset (async, active-high), push/wdata (write side),
//        pop/rdata (read side, rdata is the current head word, show-ahead),
//        full, empty status flags.
// A push while full is accepted when a pop happens in the same cycle.
module enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wptr;
    logic [PW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[PW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[PW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);

endmodule

// File: rtl/instr_encode_loader.sv
// instr_encode_loader -- packs decoded BUBBLE fields into 32-bit words and
// writes them to consecutive instruction-memory addresses.
// Ports: clk, reset (async, active-high); start/base_addr open a session;
//        in_valid/in_ready stream of fields (in_id, in_rs, in_rt, in_rd,
//        in_imm, in_last); mem_busy stalls writes; mem_we/mem_addr/mem_wdata
//        write port; count = words written this session; done; err (sticky
//        illegal opcode).
// Build option: define ENC_ILLEGAL_TRAP_EN to abort the session on an illegal
// opcode; otherwise the illegal word is dropped and loading continues.
module instr_encode_loader
    import bubble_isa_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_id,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    input  logic              mem_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W-1:0] count,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              last_seen;

    fmt_t        fmt;
    logic [31:0] enc_word;
    logic        accept;
    logic        legal;
    logic        push_word;
    logic        do_write;
    logic        bypass;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_head;
    logic [31:0] wr_word;

    // Packer
    always_comb begin
        fmt      = opcode_fmt(in_id);
        enc_word = '0;
        case (fmt)
            FMT_R: begin
                enc_word[OP_LSB +: 6] = in_id;
                enc_word[RS_LSB +: 5] = in_rs;
                enc_word[RT_LSB +: 5] = in_rt;
                enc_word[RD_LSB +: 5] = in_rd;
            end
            FMT_I: begin
                enc_word[OP_LSB +: 6]    = in_id;
                enc_word[RS_LSB +: 5]    = in_rs;
                enc_word[RT_LSB +: 5]    = in_rt;
                enc_word[IMM16_W-1:0]    = in_imm[IMM16_W-1:0];
            end
            FMT_J: begin
                enc_word[OP_LSB +: 6]    = in_id;
                enc_word[TGT_W-1:0]      = in_imm[TGT_W-1:0];
            end
            default: enc_word = '0;
        endcase
    end

    assign in_ready  = (state == S_LOAD) && !fifo_full && !last_seen;
    assign accept    = in_valid && in_ready;
    assign legal     = (fmt != FMT_ILL);
    assign push_word = accept && legal;

    // An incoming word bypasses an empty FIFO so it reaches memory one cycle
    // after acceptance; otherwise the FIFO head is written first to keep order.
    assign do_write  = !mem_busy && (!fifo_empty || push_word);
    assign bypass    = fifo_empty && push_word && !mem_busy;
    assign fifo_push = push_word && !bypass;
    assign fifo_pop  = do_write && !fifo_empty;
    assign wr_word   = fifo_empty ? enc_word : fifo_head;

    enc_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (enc_word),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            addr      <= '0;
            last_seen <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= do_write;
            if (do_write) begin
                mem_addr  <= addr;
                mem_wdata <= wr_word;
                addr      <= addr + 1'b1;
                count     <= (count == '1) ? count : count + 1'b1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        addr      <= base_addr;
                        count     <= '0;
                        err       <= 1'b0;
                        last_seen <= 1'b0;
                        done      <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (!legal) begin
                            err <= 1'b1;
`ifdef ENC_ILLEGAL_TRAP_EN
                            last_seen <= 1'b1;
`else
                            if (in_last) last_seen <= 1'b1;
`endif
                        end else if (in_last) begin
                            last_seen <= 1'b1;
                        end
                    end
                    // No pushes follow last_seen, so an empty FIFO here means
                    // the final write is either on mem_we now or already done.
                    if (last_seen && fifo_empty) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// tb_instr_encode_loader -- directed self-checking bench for instr_encode_loader.
// A reference model derives each expected memory write (address, word) from
// the ISA packing rules whenever a bundle is accepted; a compare thread checks
// every mem_we cycle against it, and literal values pin the key vectors.
module tb_instr_encode_loader;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    in_id;
    logic [4:0]    in_rs;
    logic [4:0]    in_rt;
    logic [4:0]    in_rd;
    logic [25:0]   in_imm;
    logic          in_last;
    logic          mem_busy;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW-1:0] count;
    logic          done;
    logic          err;

    instr_encode_loader #(
        .ADDR_W(AW),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_id     (in_id),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .in_last   (in_last),
        .mem_busy  (mem_busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [AW-1:0] model_addr;
    logic [AW-1:0] exp_addr [256];
    logic [31:0]   exp_data [256];
    int            exp_wr = 0;
    int            exp_rd = 0;
    int            sess_words = 0;
    int            sess_writes = 0;
    bit            err_exp = 1'b0;
    bit            aborted = 1'b0;
    int            accepts = 0;

    // write log
    logic [AW-1:0] log_addr [256];
    logic [31:0]   log_data [256];
    int            log_cyc  [256];
    int            n_log = 0;
    int            cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_legal(input int id);
        return (id == 0 || id == 1 || id == 3 || id == 6 || id == 8 ||
                id == 9 || id == 16 || id == 19);
    endfunction

    // word = id*2^26 + fields, by format class
    function automatic logic [31:0] model_word(input int id, input int rs, input int rt,
                                               input int rd, input int imm);
        longint w;
        if (id == 16) begin
            w = longint'(id) * 64'd67108864 + longint'(imm % 67108864);
        end else begin
            w = longint'(id) * 64'd67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536;
            if (id == 0 || id == 3 || id == 19) w = w + longint'(rd) * 2048;
            else                                w = w + longint'(imm % 65536);
        end
        return w[31:0];
    endfunction

    task automatic do_start(input int base);
        start     = 1'b1;
        base_addr = base[AW-1:0];
        @(posedge clk);
        #1;
        start       = 1'b0;
        model_addr  = base[AW-1:0];
        sess_words  = 0;
        sess_writes = 0;
        err_exp     = 1'b0;
        aborted     = 1'b0;
    endtask

    task automatic send(input int id, input int rs, input int rt, input int rd,
                        input int imm, input bit last);
        bit got;
        in_id    = id[5:0];
        in_rs    = rs[4:0];
        in_rt    = rt[4:0];
        in_rd    = rd[4:0];
        in_imm   = imm[25:0];
        in_last  = last;
        in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("accept_timeout", {63'd0, in_ready}, 64'd1);
        end else begin
            accepts++;
            if (is_legal(id)) begin
                exp_addr[exp_wr] = model_addr;
                exp_data[exp_wr] = model_word(id, rs, rt, rd, imm);
                exp_wr++;
                model_addr = model_addr + 1'b1;
                sess_words++;
            end else begin
                err_exp = 1'b1;
`ifdef ENC_ILLEGAL_TRAP_EN
                aborted = 1'b1;
`endif
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done", {63'd0, done}, 64'd1);
        chk("count_final", {54'd0, count}, 64'(sess_words));
        chk("err_final", {63'd0, err}, {63'd0, err_exp});
        chk("pending_words", 64'(exp_wr - exp_rd), 64'd0);
        chk("ready_in_done", {63'd0, in_ready}, 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        in_id     = '0;
        in_rs     = '0;
        in_rt     = '0;
        in_rd     = '0;
        in_imm    = '0;
        in_last   = 1'b0;
        mem_busy  = 1'b0;

        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (reset) begin
                    chk("we_in_reset", {63'd0, mem_we}, 64'd0);
                end else if (mem_we) begin
                    if (exp_rd < exp_wr) begin
                        chk("wr_addr", {54'd0, mem_addr}, {54'd0, exp_addr[exp_rd]});
                        chk("wr_data", {32'd0, mem_wdata}, {32'd0, exp_data[exp_rd]});
                        exp_rd++;
                    end else begin
                        chk("unexpected_write", {63'd0, mem_we}, 64'd0);
                    end
                    sess_writes++;
                    chk("count_run", {54'd0, count}, 64'(sess_writes));
                    log_addr[n_log] = mem_addr;
                    log_data[n_log] = mem_wdata;
                    log_cyc[n_log]  = cyc;
                    n_log++;
                end
            end
        join_none

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_we", {63'd0, mem_we}, 64'd0);
        chk("rst_addr", {54'd0, mem_addr}, 64'd0);
        chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_count", {54'd0, count}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: single ADD, one-cycle latency
        do_start(32'h010);
        send(0, 3, 5, 1, 0, 1'b1);
        @(negedge clk);
        chk("t1_we_latency", {63'd0, mem_we}, 64'd1);
        chk("t1_addr", {54'd0, mem_addr}, 64'h010);
        chk("t1_wdata", {32'd0, mem_wdata}, 64'h00650800);
        wait_done();

        // 2: ADDI, LW, SW streamed
        do_start(32'h010);
        send(1, 2, 1, 0, 100, 1'b0);
        send(8, 2, 1, 0, 100, 1'b0);
        send(9, 2, 1, 0, 100, 1'b1);
        wait_done();
        chk("t2_count", {54'd0, count}, 64'd3);
        chk("t2_a0", {54'd0, log_addr[n_log-3]}, 64'h010);
        chk("t2_d0", {32'd0, log_data[n_log-3]}, 64'h04410064);
        chk("t2_a2", {54'd0, log_addr[n_log-1]}, 64'h012);
        chk("t2_d1", {32'd0, log_data[n_log-2]}, 64'h20410064);
        chk("t2_d2", {32'd0, log_data[n_log-1]}, 64'h24410064);

        // 3: J then SLT back-to-back
        do_start(32'h100);
        send(16, 0, 0, 0, 100, 1'b0);
        send(19, 3, 6, 1, 0, 1'b1);
        wait_done();
        chk("t3_d0", {32'd0, log_data[n_log-2]}, 64'h40000064);
        chk("t3_d1", {32'd0, log_data[n_log-1]}, 64'h4C660800);
        chk("t3_b2b_gap", 64'(log_cyc[n_log-1] - log_cyc[n_log-2]), 64'd1);

        // 4: memory busy while streaming six words
        do_start(32'h200);
        accepts  = 0;
        mem_busy = 1'b1;
        fork
            begin
                send(0, 1, 2, 3, 0, 1'b0);
                send(1, 4, 5, 0, 16'h1234, 1'b0);
                send(3, 6, 7, 8, 0, 1'b0);
                send(6, 9, 10, 0, 16'hBEEF, 1'b0);
                send(16, 0, 0, 0, 26'h3ABCDEF, 1'b0);
                send(19, 31, 30, 29, 0, 1'b1);
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                chk("t4_accepts_busy", 64'(accepts), 64'd4);
                chk("t4_ready_full", {63'd0, in_ready}, 64'd0);
                chk("t4_no_write_busy", 64'(sess_writes), 64'd0);
                mem_busy = 1'b0;
            end
        join
        wait_done();
        chk("t4_count", {54'd0, count}, 64'd6);

        // 5: address wrap
        do_start(32'h3FF);
        send(0, 1, 1, 1, 0, 1'b0);
        send(6, 2, 2, 0, 7, 1'b1);
        wait_done();
        chk("t5_a0", {54'd0, log_addr[n_log-2]}, 64'h3FF);
        chk("t5_a1", {54'd0, log_addr[n_log-1]}, 64'h000);

        // 6: illegal opcode mid-stream
        do_start(32'h020);
        send(0, 3, 5, 1, 0, 1'b0);
        send(2, 1, 1, 1, 5, 1'b0);
        if (!aborted) begin
            send(6, 4, 4, 0, 42, 1'b0);
            send(9, 2, 1, 0, 100, 1'b1);
        end
        wait_done();
        chk("t6_err", {63'd0, err}, 64'd1);
`ifdef ENC_ILLEGAL_TRAP_EN
        chk("t6_count_trap", {54'd0, count}, 64'd1);
`else
        chk("t6_count_skip", {54'd0, count}, 64'd3);
        chk("t6_skip_addr", {54'd0, log_addr[n_log-2]}, 64'h021);
        chk("t6_skip_data", {32'd0, log_data[n_log-2]}, 64'h1884002A);
`endif

        // reset mid-drain
        do_start(32'h040);
        mem_busy = 1'b1;
        send(0, 1, 2, 3, 0, 1'b0);
        send(3, 4, 5, 6, 0, 1'b0);
        send(19, 7, 8, 9, 0, 1'b0);
        mem_busy = 1'b0;
        @(posedge clk);
        #1;
        chk("rd_first_write", {63'd0, mem_we}, 64'd1);
        @(negedge clk);
        #2;
        reset  = 1'b1;
        exp_rd = exp_wr;
        #1;
        chk("rd_async_we", {63'd0, mem_we}, 64'd0);
        repeat (3) @(negedge clk);
        chk("rd_count", {54'd0, count}, 64'd0);
        chk("rd_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("rd_idle_done", {63'd0, done}, 64'd0);
        chk("rd_idle_ready", {63'd0, in_ready}, 64'd0);
        chk("rd_idle_we", {63'd0, mem_we}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
